// File: rtl/bit_repeat_upsample_fifo.sv
// Symbol-repeat upsampler with input FIFO for the BTLE TX path (bit source -> Gaussian filter).
// Build option BIT_REPEAT_UPSAMPLE_IDLE_HOLD_EN: hold the last symbol on out_data while idle.

// Generic FIFO: register-array storage with an occupancy counter.
// Latency: a written entry is visible on rd_data / empty one clock after the write.
// Backpressure: full is decoded from the count only, so it stays high on a same-cycle read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !rd_en) count <= count + CW'(1);
      else if (!wr_en && rd_en) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end
endmodule

// Repeats each buffered symbol SAMPLE_PER_SYMBOL times, one strobe every CLK_PER_SAMPLE clocks.
// Latency: symbol pushed at edge N into an idle, empty block gives its first strobe after edge N+1.
// Backpressure: in_ready low while the FIFO holds FIFO_DEPTH entries; output side has no ready.
module bit_repeat_upsample_fifo #(
  parameter int SAMPLE_PER_SYMBOL = 8,
  parameter int CLK_PER_SAMPLE    = 2,
  parameter int SYMBOL_WIDTH      = 1,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SYMBOL_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    underrun
);
  localparam int PH_W = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
  localparam int SC_W = $clog2(SAMPLE_PER_SYMBOL);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(CLK_PER_SAMPLE - 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(SAMPLE_PER_SYMBOL - 1);

  typedef struct packed {
    logic                    last;
    logic [SYMBOL_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  entry_t                  wr_ent;
  entry_t                  head;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  logic [SYMBOL_WIDTH-1:0] cur_data;
  logic                    cur_last;
  logic                    cur_first;
  logic                    in_pkt;
  logic [PH_W-1:0]         ph;
  logic [SC_W-1:0]         sc;
  logic                    ph_wrap;
  logic                    sym_end;

  assign in_ready    = ~fifo_full;
  assign push        = in_valid & in_ready;
  assign wr_ent.last = in_last;
  assign wr_ent.data = in_data;

  assign ph_wrap = (ph == PH_MAX);
  assign sym_end = (state == RUN) & ph_wrap & (sc == SC_MAX);
  // A last symbol never chains into the next packet, which guarantees an idle gap.
  assign pop     = ~fifo_empty & ((state == IDLE) | (sym_end & ~cur_last));

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_data(wr_ent),
    .rd_en  (pop),
    .rd_data(head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_data  <= '0;
      cur_last  <= 1'b0;
      cur_first <= 1'b0;
      in_pkt    <= 1'b0;
      ph        <= '0;
      sc        <= '0;
      underrun  <= 1'b0;
    end else if (state == IDLE) begin
      if (!fifo_empty) begin
        cur_data  <= head.data;
        cur_last  <= head.last;
        cur_first <= ~in_pkt;
        in_pkt    <= 1'b1;
        ph        <= '0;
        sc        <= '0;
        state     <= RUN;
      end
    end else begin
      if (!ph_wrap) begin
        ph <= ph + PH_W'(1);
      end else begin
        ph        <= '0;
        cur_first <= 1'b0;
        if (sc != SC_MAX) begin
          sc <= sc + SC_W'(1);
        end else begin
          sc <= '0;
          if (cur_last) begin
            in_pkt <= 1'b0;
            state  <= IDLE;
          end else if (!fifo_empty) begin
            cur_data <= head.data;
            cur_last <= head.last;
          end else begin
            // Starved mid-packet: in_pkt stays set so the late symbol continues this packet.
            underrun <= 1'b1;
            state    <= IDLE;
          end
        end
      end
    end
  end

  assign out_valid = (state == RUN) & (ph == '0);
  assign out_first = out_valid & cur_first & (sc == '0);
  assign out_last  = out_valid & cur_last & (sc == SC_MAX);

`ifdef BIT_REPEAT_UPSAMPLE_IDLE_HOLD_EN
  assign out_data = cur_data;
`else
  assign out_data = (state == RUN) ? cur_data : '0;
`endif
endmodule

// File: tb/tb_bit_repeat_upsample_fifo.sv
// Scoreboard bench: default-parameter instance plus a CLK_PER_SAMPLE=1 / 4-sample / 2-bit instance.
module tb_bit_repeat_upsample_fifo;
  logic       clk;
  logic       rst;
  logic [0:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [0:0] out_data;
  logic       out_valid;
  logic       out_first;
  logic       out_last;
  logic       underrun;

  logic       rst_p;
  logic [1:0] pin_data;
  logic       pin_valid;
  logic       pin_last;
  logic       pin_ready;
  logic [1:0] pout_data;
  logic       pout_valid;
  logic       pout_first;
  logic       pout_last;
  logic       punderrun;

`ifdef BIT_REPEAT_UPSAMPLE_IDLE_HOLD_EN
  localparam logic [0:0] IDLE_EXP = 1'b1;
`else
  localparam logic [0:0] IDLE_EXP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [2:0] exp_q[$];
  logic [3:0] pexp_q[$];
  logic [2:0] e;
  logic [3:0] pe;
  logic       m_in_pkt = 1'b0;
  logic       pm_in_pkt = 1'b0;
  int         strobe_cnt = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  int         acc_cnt = 0;
  int         stall_at = -1;
  int         p_prev = 0;
  int         p_cnt = 0;

  bit_repeat_upsample_fifo #(
    .SAMPLE_PER_SYMBOL(8), .CLK_PER_SAMPLE(2), .SYMBOL_WIDTH(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .underrun(underrun)
  );

  bit_repeat_upsample_fifo #(
    .SAMPLE_PER_SYMBOL(4), .CLK_PER_SAMPLE(1), .SYMBOL_WIDTH(2), .FIFO_DEPTH(4)
  ) dut_p (
    .clk(clk), .rst(rst_p), .in_data(pin_data), .in_valid(pin_valid), .in_last(pin_last),
    .in_ready(pin_ready), .out_data(pout_data), .out_valid(pout_valid), .out_first(pout_first),
    .out_last(pout_last), .underrun(punderrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: pop one expected {data, first, last} per strobe.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      strobe_cnt++;
      if (out_first) first_cyc = cyc;
      if (out_last) last_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_data_first_last", 32'({out_data, out_first, out_last}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_p && pout_valid) begin
      p_cnt++;
      if (!pout_first) chk("p_strobe_gap", 32'(cyc - p_prev), 32'd1);
      p_prev = cyc;
      if (pexp_q.size() == 0) begin
        chk("p_unexpected_strobe", 32'(pout_data), 32'hFFFF_FFFF);
      end else begin
        pe = pexp_q.pop_front();
        chk("p_strobe_data_first_last", 32'({pout_data, pout_first, pout_last}), 32'(pe));
      end
    end
  end

  task automatic push(input logic [0:0] d, input logic l);
    int n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    if (!in_ready && stall_at < 0) stall_at = acc_cnt;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("push_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc_cnt++;
      for (int k = 0; k < 8; k++)
        exp_q.push_back({d, (k == 0) && !m_in_pkt, l && (k == 7)});
      m_in_pkt = !l;
    end
  endtask

  task automatic push_p(input logic [1:0] d, input logic l);
    int n = 0;
    pin_data  = d;
    pin_last  = l;
    pin_valid = 1'b1;
    while (!pin_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("p_push_timeout", 32'(pin_ready), 32'd1);
      pin_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++)
        pexp_q.push_back({d, (k == 0) && !pm_in_pkt, l && (k == 3)});
      pm_in_pkt = !l;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pexp_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(exp_q.size() + pexp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_p = 1'b1;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    pin_data = '0; pin_valid = 1'b0; pin_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_outputs", 32'({out_data, out_valid, out_first, out_last, underrun}), 32'd0);
    // Pushes while rst is high must be ignored.
    in_valid = 1'b1; in_data = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0; rst_p = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("no_push_during_reset", 32'(strobe_cnt), 32'd0);

    // Parametrised instance: 10 x4 then 01 x4, back to back.
    push_p(2'b10, 1'b0);
    push_p(2'b01, 1'b1);
    pin_valid = 1'b0;
    drain("p_drain", 100);
    chk("p_strobe_count", 32'(p_cnt), 32'd8);

    // Single packet 1,0,1.
    strobe_cnt = 0;
    push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    push(1'b1, 1'b1);
    in_valid = 1'b0;
    drain("pkt_drain", 200);
    chk("pkt_strobe_count", 32'(strobe_cnt), 32'd24);
    chk("pkt_span", 32'(last_cyc - first_cyc), 32'd46);
    chk("pkt_underrun", 32'(underrun), 32'd0);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_out_data", 32'(out_data), 32'(IDLE_EXP));

    // Backpressure: six symbols back to back.
    strobe_cnt = 0; acc_cnt = 0; stall_at = -1;
    push(1'b1, 1'b0);
    push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    push(1'b0, 1'b1);
    in_valid = 1'b0;
    chk("bp_first_stall_after", 32'(stall_at), 32'd5);
    drain("bp_drain", 300);
    chk("bp_strobe_count", 32'(strobe_cnt), 32'd48);
    chk("bp_span_no_gaps", 32'(last_cyc - first_cyc), 32'd94);
    chk("bp_underrun", 32'(underrun), 32'd0);

    // Underrun: late second symbol continues the same packet.
    strobe_cnt = 0;
    push(1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("underrun_strobes_before", 32'(strobe_cnt), 32'd8);
    push(1'b0, 1'b1);
    in_valid = 1'b0;
    drain("underrun_drain", 200);
    chk("underrun_sticky", 32'(underrun), 32'd1);
    chk("underrun_strobe_count", 32'(strobe_cnt), 32'd16);
    rst = 1'b1;
    #1;
    chk("underrun_cleared_by_rst", 32'(underrun), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of a packet, at strobe 5.
    strobe_cnt = 0;
    push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    push(1'b1, 1'b1);
    in_valid = 1'b0;
    begin
      int n = 0;
      while (strobe_cnt < 5 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk("midrst_reach_strobe5", 32'(strobe_cnt), 32'd5);
    end
    rst = 1'b1;
    exp_q.delete();
    m_in_pkt = 1'b0;
    #1;
    chk("midrst_outputs", 32'({out_data, out_valid, out_first, out_last, underrun}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("midrst_held_outputs", 32'({out_data, out_valid, out_first, out_last}), 32'd0);
    rst = 1'b0;
    strobe_cnt = 0;
    push(1'b1, 1'b1);
    in_valid = 1'b0;
    drain("midrst_drain", 200);
    chk("midrst_new_pkt_strobes", 32'(strobe_cnt), 32'd8);
    chk("midrst_idle_out_data", 32'(out_data), 32'(IDLE_EXP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
